seg7_scan: RTL and testbench

//   Parametrised multiplexed 7-segment scanner for board debug displays (keyboard data, PIA state, etc.).

---
 rtl/seg7_scan.sv | 124 ++++++++++++
 tb/tb_seg7_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Multiplexed N-digit 7-segment scanner: hex decode, decimal points, per-digit enable,
// leading-zero blanking, anti-ghosting blank interval and a per-frame input snapshot.
module seg7_scan #(
  parameter int DIGITS         = 6,
  parameter int DIV            = 1024,
  parameter int BLANK          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en,
  input  logic                  lz_blank,
  output logic [6:0]            segments,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digits,
  output logic                  frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Pin levels for "off"; XOR with an active-high pattern gives the pin level.
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   snap_din;
  logic [DIGITS-1:0]     snap_dp;
  logic [DIGITS-1:0]     snap_en;
  logic                  snap_lz;

  logic                  cap;
  logic [4*DIGITS-1:0]   cur_din;
  logic [DIGITS-1:0]     cur_dp;
  logic [DIGITS-1:0]     cur_en;
  logic                  cur_lz;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic                  suppressed;
  logic                  lit;
  logic [6:0]            seg_p0;
  logic                  dp_p0;
  logic [DIGITS-1:0]     dig_p0;

  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [DIGITS-1:0]     dig_p1;
  logic                  vld_p1;

  // Stage p0: decode the slot selected by prescaler/idx. In the capture cycle the
  // live inputs are used so the slot always shows what the snapshot is about to hold.
  always_comb begin
    cap      = (presc == '0) && (idx == '0);
    cur_din  = cap ? din      : snap_din;
    cur_dp   = cap ? dp       : snap_dp;
    cur_en   = cap ? en       : snap_en;
    cur_lz   = cap ? lz_blank : snap_lz;
    nib      = cur_din[{idx, 2'b00} +: 4];
    upper_nz = 1'b0;
    // Disabled digits never keep a lower zero lit.
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx)) && cur_en[j] && (cur_din[4*j +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    suppressed = cur_lz && (idx != '0) && !upper_nz;
    lit        = (presc >= PW'(BLANK)) && cur_en[idx] && !suppressed;
    seg_p0     = lit ? hex7(nib) : 7'h00;
    dp_p0      = lit & cur_dp[idx];
    dig_p0     = '0;
    if (lit) dig_p0[idx] = 1'b1;
  end

  // Stage p1: registered pins; frame marks the cycle after the snapshot capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc    <= '0;
      idx      <= '0;
      snap_din <= '0;
      snap_dp  <= '0;
      snap_en  <= '0;
      snap_lz  <= 1'b0;
      seg_p1   <= SEG_OFF;
      dp_p1    <= DP_OFF;
      dig_p1   <= DIG_OFF;
      vld_p1   <= 1'b0;
    end else begin
      if (presc == PW'(DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (cap) begin
        snap_din <= din;
        snap_dp  <= dp;
        snap_en  <= en;
        snap_lz  <= lz_blank;
      end
      seg_p1 <= seg_p0 ^ SEG_OFF;
      dp_p1  <= dp_p0 ^ DP_OFF;
      dig_p1 <= dig_p0 ^ DIG_OFF;
      vld_p1 <= cap;
    end
  end

  assign segments = seg_p1;
  assign dp_out   = dp_p1;
  assign digits   = dig_p1;
  assign frame    = vld_p1;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: two instances (4-digit active-low, 1-digit active-high);
// stimulus pushes the lit windows of each captured frame, monitors pop them as windows open.
module tb_seg7_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: DIGITS=4 DIV=8 BLANK=2, active-low pins
  logic        reset_a;
  logic [15:0] din_a;
  logic [3:0]  dp_a, en_a;
  logic        lz_a;
  logic [6:0]  seg_a;
  logic        dpo_a;
  logic [3:0]  dig_a;
  logic        frame_a;

  // Instance B: DIGITS=1 DIV=8 BLANK=2, active-high pins
  logic        reset_b;
  logic [3:0]  din_b;
  logic [0:0]  dp_b, en_b;
  logic        lz_b;
  logic [6:0]  seg_b;
  logic        dpo_b;
  logic [0:0]  dig_b;
  logic        frame_b;

  seg7_scan #(.DIGITS(4), .DIV(8), .BLANK(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset_a), .din(din_a), .dp(dp_a), .en(en_a), .lz_blank(lz_a),
    .segments(seg_a), .dp_out(dpo_a), .digits(dig_a), .frame(frame_a));

  seg7_scan #(.DIGITS(1), .DIV(8), .BLANK(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset_b), .din(din_b), .dp(dp_b), .en(en_b), .lz_blank(lz_b),
    .segments(seg_b), .dp_out(dpo_b), .digits(dig_b), .frame(frame_b));

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  bit mon_a = 0, mon_b = 0, done_a = 0, done_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_frame_a();
    int k = 0;
    do begin @(negedge clk); k++; end while (frame_a !== 1'b1 && k < 100);
    if (frame_a !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL a_frame_timeout: actual no pulse in %0d cycles required pulse", k);
    end
  endtask

  task automatic wait_frame_b();
    int k = 0;
    do begin @(negedge clk); k++; end while (frame_b !== 1'b1 && k < 100);
    if (frame_b !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL b_frame_timeout: actual no pulse in %0d cycles required pulse", k);
    end
  endtask

  task automatic push_a(input logic [3:0] d, input logic [6:0] s, input logic p);
    q_a.push_back({d, s, p});
  endtask

  task automatic push4_a(input logic [6:0] s);
    push_a(4'hE, s, 1'b1); push_a(4'hD, s, 1'b1); push_a(4'hB, s, 1'b1); push_a(4'h7, s, 1'b1);
  endtask

  task automatic push_b(input logic [6:0] s, input logic p);
    q_b.push_back({3'b000, 1'b1, s, p});
  endtask

  // Monitor A
  logic        act_a, actp_a = 1'b0, unst_a;
  logic [11:0] pins_a, win_a, exp_a;
  int          len_a, fcnt_a;
  bit          fhave_a = 0;
  always @(negedge clk) if (mon_a) begin
    act_a  = (dig_a != 4'hF);
    pins_a = {dig_a, seg_a, dpo_a};
    if (act_a && !actp_a) begin
      len_a = 1; unst_a = 1'b0; win_a = pins_a;
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_window: actual %0h required no window", pins_a);
      end else begin
        exp_a = q_a.pop_front();
        chk("a_window", pins_a, exp_a);
      end
    end else if (act_a) begin
      len_a++;
      if (pins_a != win_a) unst_a = 1'b1;
    end else begin
      if (actp_a && reset_a) begin
        chk("a_window_len", len_a, 6);
        chk("a_window_stable", unst_a, 0);
      end
      chk("a_dark_pins", {seg_a, dpo_a}, 8'hFF);
    end
    actp_a = act_a;
    if (!reset_a) fhave_a = 0;
    else if (frame_a) begin
      if (fhave_a) chk("a_frame_period", fcnt_a, 32);
      fhave_a = 1; fcnt_a = 1;
    end else fcnt_a++;
  end

  // Monitor B
  logic        act_b, actp_b = 1'b0, unst_b;
  logic [11:0] pins_b, win_b, exp_b;
  int          len_b, fcnt_b;
  bit          fhave_b = 0;
  always @(negedge clk) if (mon_b) begin
    act_b  = (dig_b != 1'b0);
    pins_b = {3'b000, dig_b, seg_b, dpo_b};
    if (act_b && !actp_b) begin
      len_b = 1; unst_b = 1'b0; win_b = pins_b;
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_window: actual %0h required no window", pins_b);
      end else begin
        exp_b = q_b.pop_front();
        chk("b_window", pins_b, exp_b);
      end
    end else if (act_b) begin
      len_b++;
      if (pins_b != win_b) unst_b = 1'b1;
    end else begin
      if (actp_b && reset_b) begin
        chk("b_window_len", len_b, 6);
        chk("b_window_stable", unst_b, 0);
      end
      chk("b_dark_pins", {seg_b, dpo_b}, 8'h00);
    end
    actp_b = act_b;
    if (!reset_b) fhave_b = 0;
    else if (frame_b) begin
      if (fhave_b) chk("b_frame_period", fcnt_b, 8);
      fhave_b = 1; fcnt_b = 1;
    end else fcnt_b++;
  end

  // Stimulus A
  initial begin
    reset_a = 1'b0; din_a = 16'h12AF; dp_a = 4'h0; en_a = 4'hF; lz_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_rst_digits", dig_a, 4'hF);
    chk("a_rst_segments", seg_a, 7'h7F);
    chk("a_rst_dp", dpo_a, 1'b1);
    chk("a_rst_frame", frame_a, 1'b0);
    mon_a = 1; reset_a = 1'b1;
    // plain hex scan
    for (int f = 0; f < 2; f++) begin
      wait_frame_a(); chk("a_drained", q_a.size(), 0);
      push_a(4'hE, 7'h0E, 1'b1); push_a(4'hD, 7'h08, 1'b1);
      push_a(4'hB, 7'h24, 1'b1); push_a(4'h7, 7'h79, 1'b1);
    end
    // leading-zero blanking; dp on a suppressed digit stays dark
    din_a = 16'h0030; lz_a = 1'b1; dp_a = 4'b0100;
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    push_a(4'hE, 7'h40, 1'b1); push_a(4'hD, 7'h30, 1'b1);
    din_a = 16'h0000; dp_a = 4'h0;
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    push_a(4'hE, 7'h40, 1'b1);
    // disabled nonzero digit above does not keep a zero lit
    din_a = 16'h0503; en_a = 4'b1011;
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    push_a(4'hE, 7'h30, 1'b1);
    // mid-frame input change shows only from the next frame
    din_a = 16'h1111; lz_a = 1'b0; en_a = 4'hF;
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    push4_a(7'h79);
    repeat (12) @(negedge clk);
    din_a = 16'h2222;
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    push4_a(7'h24);
    // enables and decimal point
    din_a = 16'h12AF; en_a = 4'b0101; dp_a = 4'b0001;
    for (int f = 0; f < 2; f++) begin
      wait_frame_a(); chk("a_drained", q_a.size(), 0);
      push_a(4'hE, 7'h0E, 1'b0); push_a(4'hB, 7'h24, 1'b1);
    end
    // reset in the middle of an active slot
    din_a = 16'h1111; en_a = 4'hF; dp_a = 4'h0;
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    push4_a(7'h79);
    repeat (12) @(negedge clk);
    chk("a_pre_reset_active", dig_a, 4'hD);
    reset_a = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk("a_midrst_digits", dig_a, 4'hF);
    chk("a_midrst_segments", seg_a, 7'h7F);
    chk("a_midrst_dp", dpo_a, 1'b1);
    chk("a_midrst_frame", frame_a, 1'b0);
    @(negedge clk);
    chk("a_midrst_frame2", frame_a, 1'b0);
    reset_a = 1'b1;
    @(negedge clk);
    chk("a_frame_after_release", frame_a, 1'b1);
    push4_a(7'h79);
    wait_frame_a(); chk("a_drained", q_a.size(), 0);
    mon_a = 0;
    done_a = 1;
  end

  // Stimulus B
  initial begin
    reset_b = 1'b0; din_b = 4'h8; dp_b = 1'b0; en_b = 1'b1; lz_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_rst_digits", dig_b, 1'b0);
    chk("b_rst_segments", seg_b, 7'h00);
    chk("b_rst_dp", dpo_b, 1'b0);
    chk("b_rst_frame", frame_b, 1'b0);
    mon_b = 1; reset_b = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_frame_b(); chk("b_drained", q_b.size(), 0);
      push_b(7'h7F, 1'b0);
    end
    din_b = 4'h5; dp_b = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_frame_b(); chk("b_drained", q_b.size(), 0);
      push_b(7'h6D, 1'b1);
    end
    // digit 0 is never zero-blanked
    din_b = 4'h0; dp_b = 1'b0; lz_b = 1'b1;
    wait_frame_b(); chk("b_drained", q_b.size(), 0);
    push_b(7'h3F, 1'b0);
    en_b = 1'b0;
    wait_frame_b(); chk("b_drained", q_b.size(), 0);
    wait_frame_b(); chk("b_drained", q_b.size(), 0);
    mon_b = 0;
    done_b = 1;
  end

  initial begin
    wait (done_a && done_b);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
